// File: rtl/attn_pkg.sv
// Shared attention-engine definitions: datapath widths, default row length and
// the output-stage state encoding used by the exp stage, sum logic and softmax_tx.
package attn_pkg;

    localparam int ATTN_N_ROW = 4;  // elements per row, power of two 2..8
    localparam int ATTN_EX_W  = 9;  // e^x term, UQ3.6
    localparam int ATTN_P_W   = 8;  // probability, UQ0.8

    typedef enum logic [1:0] {
        COLLECT,
        SUM,
        DIVIDE,
        SEND
    } tx_state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle over a fixed Q_W
// iterations; the first iteration runs in the start cycle using the input operands.
module seq_divider #(
    parameter int DVD_W = 17,
    parameter int DVS_W = 11,
    parameter int Q_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_done,
    output logic [Q_W-1:0]   o_quot
);
    localparam int CNT_W = $clog2(Q_W + 1);

    // Caller guarantees i_dividend >> Q_W < i_divisor, so Q_W quotient bits suffice.
    logic [DVS_W-1:0] r_rem;
    logic [DVS_W-1:0] r_div;
    logic [Q_W-1:0]   r_lo;
    logic [Q_W-1:0]   r_q;
    logic [CNT_W-1:0] r_cnt;

    logic [DVS_W-1:0] w_rem_in;
    logic [DVS_W-1:0] w_div_in;
    logic [Q_W-1:0]   w_lo_in;
    logic [Q_W-1:0]   w_q_in;
    logic [DVS_W:0]   w_shift;
    logic             w_bit;
    logic [DVS_W-1:0] w_rem_nxt;
    logic [Q_W-1:0]   w_lo_nxt;
    logic [Q_W-1:0]   w_q_nxt;

    // NOTE: combinational logic uses blocking '=' and every output gets a value on
    // every path, so no latch is inferred.
    always_comb begin
        if (i_start) begin
            w_rem_in = DVS_W'(i_dividend >> Q_W);
            w_lo_in  = i_dividend[Q_W-1:0];
            w_div_in = i_divisor;
            w_q_in   = '0;
        end else begin
            w_rem_in = r_rem;
            w_lo_in  = r_lo;
            w_div_in = r_div;
            w_q_in   = r_q;
        end
        w_shift   = {w_rem_in, w_lo_in[Q_W-1]};
        w_bit     = (w_shift >= {1'b0, w_div_in});
        w_rem_nxt = w_bit ? DVS_W'(w_shift - {1'b0, w_div_in}) : w_shift[DVS_W-1:0];
        w_lo_nxt  = {w_lo_in[Q_W-2:0], 1'b0};
        w_q_nxt   = {w_q_in[Q_W-2:0], w_bit};
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_div <= '0;
            r_lo  <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_rem <= w_rem_nxt;
            r_div <= w_div_in;
            r_lo  <= w_lo_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= CNT_W'(Q_W - 1);
        end else if (r_cnt != '0) begin
            r_rem <= w_rem_nxt;
            r_lo  <= w_lo_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Done flags the cycle computing the final bit; o_quot already includes it.
    assign o_done = !i_start && (r_cnt == CNT_W'(1));
    assign o_quot = w_q_nxt;

endmodule

// File: rtl/softmax_tx.sv
// Attention-engine output stage: buffers a row of e^x terms, sums them and streams
// each term divided by the row sum as a UQ0.8 probability over a valid/ready port.
module softmax_tx
    import attn_pkg::*;
#(
    parameter int N_ROW = ATTN_N_ROW,
    parameter int EX_W  = ATTN_EX_W,
    parameter int P_W   = ATTN_P_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_vld,
    output logic            ex_rdy,
    input  logic [EX_W-1:0] ex_data,
    output logic            mst_vld,
    input  logic            mst_rdy,
    output logic [P_W-1:0]  mst_data,
    output logic            mst_last,
    output logic            busy
);
    localparam int IDX_W = (N_ROW > 1) ? $clog2(N_ROW) : 1;
    localparam int S_W   = EX_W + IDX_W;
    localparam int DVD_W = EX_W + P_W;
    localparam int Q_W   = P_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_ROW - 1);
    localparam logic [P_W-1:0]   ZERO_SUM_P = P_W'((1 << P_W) >> IDX_W);

    tx_state_t        r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_elem;
    logic [S_W-1:0]   r_sum;
    logic [EX_W-1:0]  r_buf [N_ROW];
    logic             r_div_start;
    logic             r_mst_vld;
    logic [P_W-1:0]   r_mst_data;
    logic             r_mst_last;

    logic             w_ex_rdy;
    logic             w_accept;
    logic [S_W-1:0]   w_sum;
    logic [DVD_W-1:0] w_dividend;
    logic             w_div_done;
    logic [Q_W-1:0]   w_quot;

    assign w_ex_rdy = (r_state == COLLECT);
    assign w_accept = ex_vld && w_ex_rdy;

    // NOTE: the row buffer carries no reset; every entry is written before the
    // SUM state reads it, so reset would only cost flops and routing.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_idx] <= ex_data;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N_ROW; i++) begin
            w_sum = w_sum + S_W'(r_buf[i]);
        end
    end

    assign w_dividend = {r_buf[r_elem], {P_W{1'b0}}};

    seq_divider #(
        .DVD_W (DVD_W),
        .DVS_W (S_W),
        .Q_W   (Q_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (r_div_start),
        .i_dividend (w_dividend),
        .i_divisor  (r_sum),
        .o_done     (w_div_done),
        .o_quot     (w_quot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= COLLECT;
            r_idx       <= '0;
            r_elem      <= '0;
            r_sum       <= '0;
            r_div_start <= 1'b0;
            r_mst_vld   <= 1'b0;
            r_mst_data  <= '0;
            r_mst_last  <= 1'b0;
        end else begin
            r_div_start <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (ex_vld) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= SUM;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                SUM: begin
                    r_sum       <= w_sum;
                    r_elem      <= '0;
                    r_div_start <= 1'b1;
                    r_state     <= DIVIDE;
                end
                DIVIDE: begin
                    // An all-zero row gets a uniform distribution without dividing.
                    if (r_sum == '0) begin
                        r_mst_data <= ZERO_SUM_P;
                        r_mst_vld  <= 1'b1;
                        r_mst_last <= (r_elem == LAST_IDX);
                        r_state    <= SEND;
                    end else if (w_div_done) begin
                        r_mst_data <= w_quot[P_W] ? {P_W{1'b1}} : w_quot[P_W-1:0];
                        r_mst_vld  <= 1'b1;
                        r_mst_last <= (r_elem == LAST_IDX);
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    if (mst_rdy) begin
                        r_mst_vld  <= 1'b0;
                        r_mst_last <= 1'b0;
                        if (r_mst_last) begin
                            r_state <= COLLECT;
                        end else begin
                            r_elem      <= r_elem + 1'b1;
                            r_div_start <= 1'b1;
                            r_state     <= DIVIDE;
                        end
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign ex_rdy   = w_ex_rdy;
    assign busy     = !w_ex_rdy;
    assign mst_vld  = r_mst_vld;
    assign mst_data = r_mst_data;
    assign mst_last = r_mst_last;

endmodule
